// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard for a 5-stage MIPS-style pipeline.
// Tracks in-flight producers per architectural register (Tnew countdown and
// stage age), raises stall when a D-stage consumer needs a value too early,
// selects the forwarding source, and tracks HI/LO multiply/divide occupancy.
// Optional: define HAZARD_SCOREBOARD_PERF_EN to add a 32-bit stall_cnt output.

// One scoreboard entry: {pend, cnt, age} for a single architectural register.
module hazard_sb_entry #(
    parameter int TW     = 2,
    parameter int NSTAGE = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] tnew,
    output logic          pend,
    output logic [TW-1:0] cnt,
    output logic [1:0]    age
);
    localparam logic [1:0] AGE_LAST = 2'(NSTAGE - 1);

    // Load on producer issue; otherwise count down and age until the result
    // leaves the last forwardable stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= 1'b0;
            cnt  <= '0;
            age  <= '0;
        end else if (load) begin
            pend <= 1'b1;
            cnt  <= tnew;
            age  <= '0;
        end else if (pend) begin
            if (age == AGE_LAST) begin
                pend <= 1'b0;
                cnt  <= '0;
                age  <= '0;
            end else begin
                cnt  <= (cnt == '0) ? '0 : cnt - 1'b1;
                age  <= age + 2'd1;
            end
        end
    end
endmodule

module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int TW      = 2,
    parameter int NSTAGE  = 3,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_valid,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    input  logic [TW-1:0] rs_tuse,
    input  logic [TW-1:0] rt_tuse,
    input  logic          dst_we,
    input  logic [AW-1:0] dst_addr,
    input  logic [TW-1:0] dst_tnew,
    input  logic          md_start,
    input  logic          md_div,
    input  logic          md_use,
    output logic          stall,
    output logic [1:0]    fwd_rs_sel,
    output logic [1:0]    fwd_rt_sel,
    output logic          md_busy
`ifdef HAZARD_SCOREBOARD_PERF_EN
   ,output logic [31:0]   stall_cnt
`endif
);
    localparam int MD_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int MDW    = $clog2(MD_MAX + 1);

    logic          pend [NREG];
    logic [TW-1:0] cnt  [NREG];
    logic [1:0]    age  [NREG];
    logic          issue;

    // Register 0 never has a producer.
    assign pend[0] = 1'b0;
    assign cnt[0]  = '0;
    assign age[0]  = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_ent
        logic load;
        assign load = issue & dst_we & (dst_addr == AW'(i));
        hazard_sb_entry #(.TW(TW), .NSTAGE(NSTAGE)) u_ent (
            .clk  (clk),
            .reset(reset),
            .load (load),
            .tnew (dst_tnew),
            .pend (pend[i]),
            .cnt  (cnt[i]),
            .age  (age[i])
        );
    end

    logic          rs_pend, rt_pend;
    logic [TW-1:0] rs_cnt, rt_cnt;
    logic [1:0]    rs_age, rt_age;

    // Look up the entries for both sources; out-of-range and r0 read as idle.
    always_comb begin
        rs_pend = 1'b0; rs_cnt = '0; rs_age = '0;
        rt_pend = 1'b0; rt_cnt = '0; rt_age = '0;
        for (int i = 1; i < NREG; i++) begin
            if (rs_addr == AW'(i)) begin
                rs_pend = pend[i]; rs_cnt = cnt[i]; rs_age = age[i];
            end
            if (rt_addr == AW'(i)) begin
                rt_pend = pend[i]; rt_cnt = cnt[i]; rt_age = age[i];
            end
        end
    end

    logic [MDW-1:0] md_cnt;
    logic           hz_rs, hz_rt, hz_md;

    assign hz_rs = (rs_addr != '0) & (rs_tuse != '1) & rs_pend & (rs_cnt > rs_tuse);
    assign hz_rt = (rt_addr != '0) & (rt_tuse != '1) & rt_pend & (rt_cnt > rt_tuse);
    assign md_busy = (md_cnt != '0);
    assign hz_md = (md_start | md_use) & md_busy;
    assign stall = issue_valid & (hz_rs | hz_rt | hz_md);
    assign issue = issue_valid & ~stall;

    // Forward source is the stage the producer currently occupies, once its
    // result exists.
    assign fwd_rs_sel = ((rs_addr != '0) & rs_pend & (rs_cnt == '0)) ? rs_age + 2'd1 : 2'd0;
    assign fwd_rt_sel = ((rt_addr != '0) & rt_pend & (rt_cnt == '0)) ? rt_age + 2'd1 : 2'd0;

    // HI/LO occupancy: load the unit latency on mult/div issue, then drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            md_cnt <= '0;
        else if (issue & md_start)
            md_cnt <= md_div ? MDW'(DIV_LAT) : MDW'(MUL_LAT);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - 1'b1;
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    // Count stalled cycles; wraps naturally at 2**32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters).
module tb_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic [4:0] rs_addr, rt_addr, dst_addr;
    logic [1:0] rs_tuse, rt_tuse, dst_tnew;
    logic       dst_we, md_start, md_div, md_use;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_tuse(rs_tuse), .rt_tuse(rt_tuse),
        .dst_we(dst_we), .dst_addr(dst_addr), .dst_tnew(dst_tnew),
        .md_start(md_start), .md_div(md_div), .md_use(md_use),
        .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
`ifdef HAZARD_SCOREBOARD_PERF_EN
       ,.stall_cnt(stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        issue_valid = 1'b0;
        rs_addr = '0; rt_addr = '0; rs_tuse = '1; rt_tuse = '1;
        dst_we = 1'b0; dst_addr = '0; dst_tnew = '0;
        md_start = 1'b0; md_div = 1'b0; md_use = 1'b0;
    endtask

    task automatic producer(input logic [4:0] d, input logic [1:0] t);
        idle();
        issue_valid = 1'b1; dst_we = 1'b1; dst_addr = d; dst_tnew = t;
    endtask

    task automatic consumer_rs(input logic [4:0] a, input logic [1:0] u);
        idle();
        issue_valid = 1'b1; rs_addr = a; rs_tuse = u;
    endtask

    int n;

    initial begin
        // Reset: outputs quiet even with a consumer presented.
        reset = 1'b0;
        consumer_rs(5'd5, 2'd0);
        md_use = 1'b1;
        #3;
        chk("rst_stall", stall, 1'b0);
        chk("rst_fwd_rs", fwd_rs_sel, 2'd0);
        chk("rst_fwd_rt", fwd_rt_sel, 2'd0);
        chk("rst_md_busy", md_busy, 1'b0);
        tick();
        reset = 1'b1;
        tick();

        // Load r5 (tnew=2) then add rs=5 tuse=1: one stall cycle.
        producer(5'd5, 2'd2);
        #2 chk("ld_issue_stall", stall, 1'b0);
        tick();
        consumer_rs(5'd5, 2'd1);
        #2 chk("ld_use_stall", stall, 1'b1);
        chk("ld_use_sel_early", fwd_rs_sel, 2'd0);
        tick();
        #2 chk("ld_use_go", stall, 1'b0);
        chk("ld_use_sel_cnt1", fwd_rs_sel, 2'd0);
        tick();
        // Load result now exists and sits in W (age 2).
        consumer_rs(5'd5, 2'd0);
        #2 chk("ld_sel_w", fwd_rs_sel, 2'd3);
        chk("ld_w_stall", stall, 1'b0);
        tick();
        #2 chk("ld_cleared_sel", fwd_rs_sel, 2'd0);
        tick();

        // ALU r8 (tnew=1) then beq rs=8 tuse=0: one stall, then forward from M.
        producer(5'd8, 2'd1);
        tick();
        consumer_rs(5'd8, 2'd0);
        #2 chk("alu_beq_stall", stall, 1'b1);
        tick();
        #2 chk("alu_beq_go", stall, 1'b0);
        chk("alu_beq_sel_m", fwd_rs_sel, 2'd2);
        tick();

        // jal r31 (tnew=0) then jr 31: no stall, forward from E.
        producer(5'd31, 2'd0);
        tick();
        consumer_rs(5'd31, 2'd0);
        #2 chk("jr_stall", stall, 1'b0);
        chk("jr_sel_e", fwd_rs_sel, 2'd1);
        tick();

        // Two producers to r3; the newer (tnew=0) wins for an rt consumer.
        producer(5'd3, 2'd2);
        tick();
        producer(5'd3, 2'd0);
        tick();
        idle();
        issue_valid = 1'b1; rt_addr = 5'd3; rt_tuse = 2'd0;
        #2 chk("ovw_stall", stall, 1'b0);
        chk("ovw_rt_sel", fwd_rt_sel, 2'd1);
        chk("ovw_rs0_sel", fwd_rs_sel, 2'd0);
        tick();

        // Unused source (tuse all-ones) never stalls; used one does.
        producer(5'd9, 2'd2);
        tick();
        consumer_rs(5'd9, 2'd3);
        #1 chk("unused_src_stall", stall, 1'b0);
        rs_tuse = 2'd0;
        #1 chk("used_src_stall", stall, 1'b1);
        idle();
        // rt hazard with no issue_valid: no stall.
        rt_addr = 5'd9; rt_tuse = 2'd0;
        #1 chk("novalid_stall", stall, 1'b0);
        tick();

        // Writes to r0 are ignored.
        producer(5'd0, 2'd2);
        tick();
        consumer_rs(5'd0, 2'd0);
        #2 chk("r0_stall", stall, 1'b0);
        chk("r0_sel", fwd_rs_sel, 2'd0);
        tick();

        // A stalled instruction must not write its destination.
        producer(5'd10, 2'd2);
        tick();
        consumer_rs(5'd10, 2'd0);
        dst_we = 1'b1; dst_addr = 5'd11; dst_tnew = 2'd3;
        #2 chk("stalled_wr_stall", stall, 1'b1);
        tick();
        consumer_rs(5'd11, 2'd0);
        #2 chk("stalled_no_write", stall, 1'b0);
        idle();
        tick(); tick(); tick();

        // div then mflo: 10 stall cycles, md_busy low when the stall ends.
        idle();
        issue_valid = 1'b1; md_start = 1'b1; md_div = 1'b1;
        #2 chk("div_issue_stall", stall, 1'b0);
        tick();
        #2 chk("div_busy", md_busy, 1'b1);
        idle();
        issue_valid = 1'b1; md_use = 1'b1;
        n = 0;
        #2;
        while (stall && n < 20) begin
            n++;
            tick();
            #2;
        end
        chk("div_mflo_stalls", n, 10);
        chk("div_busy_after", md_busy, 1'b0);
        tick();

        // mult then mult: 5 stall cycles, then the second mult reloads.
        idle();
        issue_valid = 1'b1; md_start = 1'b1;
        tick();
        n = 0;
        #2;
        while (stall && n < 20) begin
            n++;
            tick();
            #2;
        end
        chk("mult_mult_stalls", n, 5);
        tick();
        idle();
        #2 chk("mult2_busy", md_busy, 1'b1);
        repeat (6) tick();
        chk("mult2_drained", md_busy, 1'b0);

        // Reset mid-flight discards the pending r5 producer.
        producer(5'd5, 2'd2);
        tick();
        idle();
        reset = 1'b0;
        #2 chk("midrst_busy", md_busy, 1'b0);
        reset = 1'b1;
        consumer_rs(5'd5, 2'd0);
        #2 chk("midrst_stall", stall, 1'b0);
        chk("midrst_sel", fwd_rs_sel, 2'd0);
        tick();

`ifdef HAZARD_SCOREBOARD_PERF_EN
        chk("perf_after_rst", stall_cnt, 32'd0);
        producer(5'd12, 2'd3);
        tick();
        consumer_rs(5'd12, 2'd0);
        tick(); tick(); tick();
        #2 chk("perf_stall_over", stall, 1'b0);
        chk("perf_three", stall_cnt, 32'd3);
        idle();
        tick();
        dut.stall_cnt = 32'hFFFF_FFFF;
        producer(5'd13, 2'd1);
        tick();
        consumer_rs(5'd13, 2'd0);
        tick();
        chk("perf_wrap", stall_cnt, 32'd0);
        idle();
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
